n0prime_param: RTL

N0PRIME_PARAM -- requirements
Module: n0prime_param

---
 rtl/n0prime_param.sv | 109 ++++++++++
 1 files changed

// File: rtl/n0prime_param.sv
// n0prime_param: bit-serial Montgomery constant generator, qinv = n^-1 and n0prime = -n^-1 mod 2^WORD.
// Define N0PRIME_SELFCHECK_EN to add a CHECK state that verifies nl*qinv == 1 and drives chk_ok.
`default_nettype none

module n0prime_param #(
  parameter int NWIDTH = 1025,
  parameter int WORD   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NWIDTH-1:0] n,
  output logic              busy,
  output logic              done,
  output logic [WORD-1:0]   qinv,
  output logic [WORD-1:0]   n0prime,
  output logic              err_even
`ifdef N0PRIME_SELFCHECK_EN
  ,
  output logic              chk_ok
`endif
);

  localparam int IW = $clog2(WORD);
  localparam logic [IW-1:0] LAST = IW'(WORD - 1);

  typedef enum logic [1:0] {IDLE, CALC, FINAL, CHECK} state_t;

  state_t          state;
  logic [WORD-1:0] nl;
  logic [WORD-1:0] y;
  logic [WORD-1:0] prod;
  logic [IW-1:0]   i;
  logic            err;

  // Only the low word of n matters; the rest is intentionally ignored.
  generate
    if (NWIDTH > WORD) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^n[NWIDTH-1:WORD];
    end
  endgenerate

  assign prod = nl * y;
  assign busy = (state != IDLE);

`ifdef N0PRIME_SELFCHECK_EN
  logic [WORD-1:0] chk_prod;
  assign chk_prod = nl * qinv;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      nl       <= '0;
      y        <= '0;
      i        <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      qinv     <= '0;
      n0prime  <= '0;
      err_even <= 1'b0;
`ifdef N0PRIME_SELFCHECK_EN
      chk_ok   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nl    <= n[WORD-1:0];
            y     <= WORD'(1);
            i     <= IW'(1);
            err   <= ~n[0];
            state <= n[0] ? CALC : FINAL;
          end
        end
        CALC: begin
          // Bit i of n*y being set means y is wrong at bit i; flipping it fixes that bit.
          if (prod[i]) y[i] <= 1'b1;
          i <= i + IW'(1);
          if (i == LAST) state <= FINAL;
        end
        FINAL: begin
          qinv     <= err ? '0 : y;
          n0prime  <= err ? '0 : (~y + WORD'(1));
          err_even <= err;
`ifdef N0PRIME_SELFCHECK_EN
          state    <= CHECK;
`else
          done     <= 1'b1;
          state    <= IDLE;
`endif
        end
`ifdef N0PRIME_SELFCHECK_EN
        CHECK: begin
          chk_ok <= (chk_prod == WORD'(1)) || err;
          done   <= 1'b1;
          state  <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
